// File: rtl/draw_bounding_box_pkg.sv
// Shared image package: image geometry, bus widths, the box-drawer FSM
// encoding and a coordinate validity helper.
package draw_bounding_box_pkg;

  localparam int unsigned ImgXsz    = 6;   // x coordinate width
  localparam int unsigned ImgYsz    = 6;   // y coordinate width
  localparam int unsigned ImgAddrsz = 12;  // image RAM address width
  localparam int unsigned ImgColsz  = 3;   // pixel colour width
  localparam int unsigned ImgXRes   = 60;  // image width in pixels
  localparam int unsigned ImgYRes   = 60;  // image height in pixels

  typedef enum logic [2:0] {
    StIdle,
    StDrawTop,
    StDrawBottom,
    StDrawLeft,
    StDrawRight,
    StFinish
  } state_e;

  // A box is rejected when its edges are swapped or it leaves the image.
  function automatic logic box_invalid(input int unsigned top,
                                       input int unsigned bottom,
                                       input int unsigned left,
                                       input int unsigned right,
                                       input int unsigned x_res,
                                       input int unsigned y_res);
    return (top > bottom) || (left > right) || (right >= x_res) || (bottom >= y_res);
  endfunction

endpackage

// File: rtl/draw_bounding_box_if.sv
// Request/write bus of the bounding-box drawer.
//   master: start, mostTop/mostBottom/mostLeft/mostRight, colour (requester side)
//   slave : wr_addr, wr_data, wr_en, busy, done, err (drawer side)
interface draw_bounding_box_if import draw_bounding_box_pkg::*; #(
  parameter int unsigned XSZ    = ImgXsz,
  parameter int unsigned YSZ    = ImgYsz,
  parameter int unsigned ADDRSZ = ImgAddrsz,
  parameter int unsigned COLSZ  = ImgColsz
);

  logic              start;
  logic [YSZ-1:0]    mostTop;
  logic [YSZ-1:0]    mostBottom;
  logic [XSZ-1:0]    mostLeft;
  logic [XSZ-1:0]    mostRight;
  logic [COLSZ-1:0]  colour;
  logic [ADDRSZ-1:0] wr_addr;
  logic [COLSZ-1:0]  wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mostTop, mostBottom, mostLeft, mostRight, colour,
    input  wr_addr, wr_data, wr_en, busy, done, err
  );

  modport slave (
    input  start, mostTop, mostBottom, mostLeft, mostRight, colour,
    output wr_addr, wr_data, wr_en, busy, done, err
  );

endinterface

// File: rtl/draw_bounding_box_address_translator.sv
// Address translator: maps pixel (x, y) to the linear image RAM address
// y * X_RES + x, computed unsigned at ADDRSZ bits.
//   x_i    : pixel column
//   y_i    : pixel row
//   addr_o : linear RAM address
module draw_bounding_box_address_translator #(
  parameter int unsigned XSZ    = 6,
  parameter int unsigned YSZ    = 6,
  parameter int unsigned ADDRSZ = 12,
  parameter int unsigned X_RES  = 60
) (
  input  logic [XSZ-1:0]    x_i,
  input  logic [YSZ-1:0]    y_i,
  output logic [ADDRSZ-1:0] addr_o
);

  localparam logic [ADDRSZ-1:0] XResA = ADDRSZ'(X_RES);

  always_comb begin
    addr_o = ADDRSZ'(y_i) * XResA + ADDRSZ'(x_i);
  end

endmodule

// File: rtl/draw_bounding_box.sv
// Bounding-box drawer: on start, writes the outline of an inclusive box into
// the image RAM one pixel per cycle (top row, bottom row, left column, right
// column), each pixel exactly once, then pulses done (with err on a bad box).
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : request inputs and RAM write / status outputs (slave modport)
module draw_bounding_box import draw_bounding_box_pkg::*; #(
  parameter int unsigned XSZ    = ImgXsz,
  parameter int unsigned YSZ    = ImgYsz,
  parameter int unsigned ADDRSZ = ImgAddrsz,
  parameter int unsigned COLSZ  = ImgColsz,
  parameter int unsigned X_RES  = ImgXRes,
  parameter int unsigned Y_RES  = ImgYRes
) (
  input logic                clk,
  input logic                resetn,
  draw_bounding_box_if.slave bus
);

  state_e           state_q;
  logic [YSZ-1:0]   top_q, bot_q, y_q;
  logic [XSZ-1:0]   left_q, right_q, x_q;
  logic [COLSZ-1:0] wr_data_q;
  logic             wr_en_q, busy_q, done_q, err_q;

  logic start_invalid;
  logic x_last;       // current row write is the last one of the row
  logic y_last;       // current column write is the last interior row
  logic tall;         // box has interior rows (height > 2)

  always_comb begin
    start_invalid = box_invalid(32'(bus.mostTop), 32'(bus.mostBottom),
                                32'(bus.mostLeft), 32'(bus.mostRight), X_RES, Y_RES);
    x_last        = (x_q == right_q);
    y_last        = (y_q == bot_q - YSZ'(1));
    tall          = ((bot_q - top_q) >= YSZ'(2));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      top_q     <= '0;
      bot_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          if (bus.start) begin
            top_q   <= bus.mostTop;
            bot_q   <= bus.mostBottom;
            left_q  <= bus.mostLeft;
            right_q <= bus.mostRight;
            busy_q  <= 1'b1;
            if (start_invalid) begin
              // Pixel position and data are left untouched so they keep
              // holding the last written values.
              state_q <= StFinish;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q   <= StDrawTop;
              x_q       <= bus.mostLeft;
              y_q       <= bus.mostTop;
              wr_data_q <= bus.colour;
              wr_en_q   <= 1'b1;
            end
          end
        end

        StDrawTop: begin
          if (!x_last) begin
            x_q <= x_q + XSZ'(1);
          end else if (top_q != bot_q) begin
            state_q <= StDrawBottom;
            x_q     <= left_q;
            y_q     <= bot_q;
          end else begin
            state_q <= StFinish;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StDrawBottom: begin
          if (!x_last) begin
            x_q <= x_q + XSZ'(1);
          end else if (tall) begin
            state_q <= StDrawLeft;
            x_q     <= left_q;
            y_q     <= top_q + YSZ'(1);
          end else begin
            state_q <= StFinish;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StDrawLeft: begin
          if (!y_last) begin
            y_q <= y_q + YSZ'(1);
          end else if (left_q != right_q) begin
            // A one-pixel-wide box has its right column already drawn.
            state_q <= StDrawRight;
            x_q     <= right_q;
            y_q     <= top_q + YSZ'(1);
          end else begin
            state_q <= StFinish;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StDrawRight: begin
          if (!y_last) begin
            y_q <= y_q + YSZ'(1);
          end else begin
            state_q <= StFinish;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StFinish: begin
          state_q <= StIdle;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  draw_bounding_box_address_translator #(
    .XSZ    (XSZ),
    .YSZ    (YSZ),
    .ADDRSZ (ADDRSZ),
    .X_RES  (X_RES)
  ) u_addr (
    .x_i    (x_q),
    .y_i    (y_q),
    .addr_o (bus.wr_addr)
  );

  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_draw_bounding_box.sv
module tb_draw_bounding_box;

  localparam int XRes   = 60;
  localparam int Budget = 300;

  typedef struct {
    string name;
    int    top, bot, left, right, col;
    bit    poke;       // pulse start with other coordinates mid-draw
    bit    exp_err;
    int    exp_count;
    int    exp_first;
    int    exp_last;
    int    exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int hold_addr;
  int hold_data;

  vec_t vecs[10];

  draw_bounding_box_if bus ();

  draw_bounding_box u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coords(input int t, input int b, input int l, input int r, input int c);
    bus.mostTop    = 6'(t);
    bus.mostBottom = 6'(b);
    bus.mostLeft   = 6'(l);
    bus.mostRight  = 6'(r);
    bus.colour     = 3'(c);
  endtask

  // Checks the quiet outputs of an idle drawer, including held address/data.
  task automatic check_idle(input string tag);
    check({tag, "_wr_en"},   int'(bus.wr_en), 0);
    check({tag, "_busy"},    int'(bus.busy), 0);
    check({tag, "_done"},    int'(bus.done), 0);
    check({tag, "_err"},     int'(bus.err), 0);
    check({tag, "_addr"},    int'(bus.wr_addr), hold_addr);
    check({tag, "_data"},    int'(bus.wr_data), hold_data);
  endtask

  task automatic run_box(input vec_t v);
    int nwr, done_cyc, last_a, e;
    // Scoreboard: outline pixels in drawing order.
    exp_q.delete();
    if (!v.exp_err) begin
      for (int x = v.left; x <= v.right; x++) exp_q.push_back(v.top * XRes + x);
      if (v.bot != v.top)
        for (int x = v.left; x <= v.right; x++) exp_q.push_back(v.bot * XRes + x);
      if (v.bot - v.top >= 2)
        for (int y = v.top + 1; y < v.bot; y++) exp_q.push_back(y * XRes + v.left);
      if (v.bot - v.top >= 2 && v.left != v.right)
        for (int y = v.top + 1; y < v.bot; y++) exp_q.push_back(y * XRes + v.right);
    end

    drive_coords(v.top, v.bot, v.left, v.right, v.col);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nwr = 0;
    done_cyc = 0;
    last_a = -1;
    check({v.name, "_busy_c1"}, int'(bus.busy), 1);
    for (int k = 1; k <= Budget; k++) begin
      if (v.poke && k == 2) begin
        bus.start = 1'b1;
        drive_coords(0, 1, 0, 1, 7);
      end
      if (v.poke && k == 3) begin
        bus.start = 1'b0;
        drive_coords(v.top, v.bot, v.left, v.right, v.col);
      end
      if (bus.err && !bus.done) check({v.name, "_err_without_done"}, int'(bus.err), 0);
      if (bus.wr_en) begin
        nwr++;
        if (exp_q.size() == 0) begin
          check({v.name, "_extra_write"}, int'(bus.wr_en), 0);
        end else begin
          e = exp_q.pop_front();
          check({v.name, "_wr_addr"}, int'(bus.wr_addr), e);
          check({v.name, "_wr_data"}, int'(bus.wr_data), v.col);
        end
        if (nwr == 1) check({v.name, "_first_addr"}, int'(bus.wr_addr), v.exp_first);
        last_a = int'(bus.wr_addr);
      end
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      tick();
    end
    check({v.name, "_done_cycle"}, done_cyc, v.exp_done);
    check({v.name, "_err"}, int'(bus.err), int'(v.exp_err));
    check({v.name, "_busy_at_done"}, int'(bus.busy), 1);
    check({v.name, "_write_count"}, nwr, v.exp_count);
    check({v.name, "_missing_writes"}, exp_q.size(), 0);
    if (v.exp_count > 0) check({v.name, "_last_addr"}, last_a, v.exp_last);
    if (!v.exp_err) begin
      hold_addr = v.exp_last;
      hold_data = v.col;
    end
    tick();
    check_idle({v.name, "_after"});
  endtask

  initial begin
    // name, top, bot, left, right, col, poke, err, count, first, last, done
    vecs[0] = '{"basic",     2,  4,  3,  5, 4, 1'b1, 1'b0,   8,  123,  185,   9};
    vecs[1] = '{"point",    10, 10, 20, 20, 2, 1'b0, 1'b0,   1,  620,  620,   2};
    vecs[2] = '{"row",       7,  7,  0,  3, 5, 1'b0, 1'b0,   4,  420,  423,   5};
    vecs[3] = '{"bad_right", 0,  5,  0, 60, 1, 1'b0, 1'b1,   0,    0,    0,   1};
    vecs[4] = '{"bad_tb",    5,  4,  0,  3, 6, 1'b0, 1'b1,   0,    0,    0,   1};
    vecs[5] = '{"frame",     0, 59,  0, 59, 7, 1'b0, 1'b0, 236,    0, 3539, 237};
    vecs[6] = '{"column",    1,  5,  7,  7, 3, 1'b1, 1'b0,   5,   67,  247,   6};
    vecs[7] = '{"two_rows",  0,  1, 58, 59, 1, 1'b0, 1'b0,   4,   58,  119,   5};
    vecs[8] = '{"bad_bot",   0, 60,  0,  0, 2, 1'b0, 1'b1,   0,    0,    0,   1};
    vecs[9] = '{"bad_lr",    0,  0,  5,  4, 4, 1'b0, 1'b1,   0,    0,    0,   1};

    resetn    = 1'b0;
    bus.start = 1'b0;
    drive_coords(0, 0, 0, 0, 0);
    hold_addr = 0;
    hold_data = 0;
    tick();
    tick();
    check_idle("reset");
    resetn = 1'b1;

    // First start lands on the first edge after reset release.
    foreach (vecs[i]) run_box(vecs[i]);

    // Abort: start a full frame, pulse start mid-draw, reset in cycle 4.
    drive_coords(0, 59, 0, 59, 5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("abort_wr_en", int'(bus.wr_en), 1);
      check("abort_addr", int'(bus.wr_addr), k - 1);
      if (k == 2) begin
        bus.start = 1'b1;
        drive_coords(2, 4, 3, 5, 4);
      end
      if (k == 3) bus.start = 1'b0;
      if (k == 4) resetn = 1'b0;
      tick();
    end
    hold_addr = 0;
    hold_data = 0;
    check_idle("abort_reset");
    resetn = 1'b1;
    run_box(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_bounding_box.md
DRAW_BOUNDING_BOX -- requirements
Module: draw_bounding_box

Interface
REQ-001 SHALL have parameter XSZ, default 6: x coordinate width.
REQ-002 SHALL have parameter YSZ, default 6: y coordinate width.
REQ-003 SHALL have parameter ADDRSZ, default 12: RAM address width.
REQ-004 SHALL have parameter COLSZ, default 3: pixel colour width.
REQ-005 SHALL have parameter X_RES, default 60: image width in pixels.
REQ-006 SHALL have parameter Y_RES, default 60: image height in pixels.
REQ-007 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-008 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port start, input, 1 bit: request to draw one box.
REQ-010 SHALL have ports mostTop and mostBottom, input, YSZ bits each: box rows, inclusive.
REQ-011 SHALL have ports mostLeft and mostRight, input, XSZ bits each: box columns, inclusive.
REQ-012 SHALL have port colour, input, COLSZ bits: outline colour.
REQ-013 SHALL have port wr_addr, output, ADDRSZ bits: image RAM write address.
REQ-014 SHALL have port wr_data, output, COLSZ bits: image RAM write data.
REQ-015 SHALL have port wr_en, output, 1 bit: image RAM write enable, one pixel per cycle.
REQ-016 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, on invalid coordinates.

Function
REQ-019 SHALL use FSM states IDLE, DRAW_TOP, DRAW_BOTTOM, DRAW_LEFT, DRAW_RIGHT, FINISH.
REQ-020 SHALL accept start only in IDLE; it latches all coordinates and colour on that edge.
REQ-021 SHALL ignore start outside IDLE, and SHALL NOT re-sample coordinates while busy.
REQ-022 SHALL treat the box as invalid if top>bottom, left>right, right>=X_RES or bottom>=Y_RES.
REQ-023 SHALL go IDLE->FINISH on an invalid box, producing done=err=1 in cycle 1 after start and zero writes.
REQ-024 SHALL otherwise go IDLE->DRAW_TOP and write (x,top) for x=left..right in ascending x.
REQ-025 SHALL then go to DRAW_BOTTOM and write (x,bottom) for x=left..right, skipping this state when top==bottom.
REQ-026 SHALL then go to DRAW_LEFT and write (left,y) for y=top+1..bottom-1, skipping this state when bottom-top<2.
REQ-027 SHALL then go to DRAW_RIGHT over the same y range at x=right, skipping this state when bottom-top<2 or left==right.
REQ-028 SHALL write every outline pixel exactly once: count = W + (H>1?W:0) + (H>2?(H-2)*(W>1?2:1):0), where W=right-left+1 and H=bottom-top+1.
REQ-029 SHALL drive wr_addr = y*X_RES + x as unsigned arithmetic with no truncation below ADDRSZ bits.
REQ-030 SHALL drive wr_data = latched colour and wr_en=1 in draw states only, with back-to-back writes and no idle cycles.
REQ-031 SHALL place the first write in cycle 1 after start, the last write in cycle N, and done in cycle N+1; FINISH->IDLE follows.
REQ-032 SHALL hold wr_en=0, done=0 and err=0 in IDLE.
REQ-033 SHALL hold wr_addr and wr_data stable (don't-care values are not permitted: hold the last value) when wr_en=0.

Reset
REQ-034 SHALL, on resetn=0 at a clock edge, force state=IDLE and wr_en=busy=done=err=0, with counters, wr_addr and wr_data cleared to 0.
REQ-035 SHALL abort a drawing in progress when reset occurs mid-operation, with no further writes and no done pulse.
REQ-036 SHALL accept start on the first edge with resetn=1 after a reset.

Structure
REQ-037 SHALL take X_RES, Y_RES, XSZ, YSZ, ADDRSZ, COLSZ and the FSM state encoding from the shared image package.
REQ-038 SHALL compute wr_addr in one instance of the existing address_translator sub-module; the x/y counters and FSM stay local.

Verification
REQ-039 SHALL cover a basic box: T=2,B=4,L=3,R=5,colour=3'b100 -> 8 writes at (3..5,2),(3..5,4),(3,3),(5,3), first addr 123, done cycle 9.
REQ-040 SHALL cover a single point: T=B=10,L=R=20 -> 1 write at addr 620, done cycle 2, err=0.
REQ-041 SHALL cover a single row: T=B=7,L=0,R=3 -> 4 writes at addrs 420..423 with no duplicate bottom row.
REQ-042 SHALL cover an invalid box: R=60 (and separately T=5,B=4) -> done=err=1 in cycle 1, wr_en never high.
REQ-043 SHALL cover a full frame: T=0,B=59,L=0,R=59 -> 236 writes, last addr 3539, done cycle 237.
REQ-044 SHALL cover abort and restart: start pulsed mid-draw is ignored, resetn=0 at cycle 4 gives wr_en=0 from the next cycle, and a fresh start then redraws correctly.
